// File: rtl/operand_fetch_pkg.sv
// Shared pipeline constants for the operand fetch stage.
package operand_fetch_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_CTRL_W = 8;
  localparam int unsigned STALL_W    = 16;

  // Architectural register that always reads as zero.
  localparam int unsigned ZERO_REG   = 0;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Operand source select: zero register, EX bypass, WB bypass, then register file.
module fwd_mux
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand_c
);

  // A load's EX result is not available yet, so it is never bypassed here.
  always_comb begin
    operand_c = rdata;
    if (addr == ADDR_W'(ZERO_REG)) begin
      operand_c = '0;
    end else if (ex_wen && !ex_is_load && (ex_addr == addr)) begin
      operand_c = ex_data;
    end else if (wb_wen && (wb_addr == addr)) begin
      operand_c = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register read, forwarding, load-use stall, output register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_rs,
  input  logic [ADDR_W-1:0]  in_rt,
  input  logic [ADDR_W-1:0]  in_rd,
  input  logic               in_use_rs,
  input  logic               in_use_rt,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic [ADDR_W-1:0]  R_addr_A,
  output logic [ADDR_W-1:0]  R_addr_B,
  input  logic [DATA_W-1:0]  rdata_A,
  input  logic [DATA_W-1:0]  rdata_B,
  input  logic               ex_wen,
  input  logic               ex_is_load,
  input  logic [ADDR_W-1:0]  ex_addr,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic               wb_wen,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [DATA_W-1:0]  out_imm,
  output logic [ADDR_W-1:0]  out_rd,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [STALL_W-1:0] stall_cnt
);

  logic [DATA_W-1:0]  opa_c, opb_c;
  logic               hazard_c, transfer_c;
  logic               valid_d;
  logic [DATA_W-1:0]  a_d, b_d, imm_d;
  logic [ADDR_W-1:0]  rd_d;
  logic [CTRL_W-1:0]  ctrl_d;
  logic [STALL_W-1:0] stall_d;

  assign R_addr_A = in_rs;
  assign R_addr_B = in_rt;

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .addr      (in_rs),
    .rdata     (rdata_A),
    .ex_wen    (ex_wen),
    .ex_is_load(ex_is_load),
    .ex_addr   (ex_addr),
    .ex_data   (ex_data),
    .wb_wen    (wb_wen),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .operand_c (opa_c)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .addr      (in_rt),
    .rdata     (rdata_B),
    .ex_wen    (ex_wen),
    .ex_is_load(ex_is_load),
    .ex_addr   (ex_addr),
    .ex_data   (ex_data),
    .wb_wen    (wb_wen),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .operand_c (opb_c)
  );

  // Load in EX whose destination feeds a source actually read by this instruction.
  assign hazard_c = ex_wen && ex_is_load && (ex_addr != ADDR_W'(ZERO_REG)) &&
                    ((in_use_rs && (ex_addr == in_rs)) ||
                     (in_use_rt && (ex_addr == in_rt)));

  assign in_ready   = rst && (!out_valid || out_ready) && !hazard_c;
  assign transfer_c = in_valid && in_ready;

  // Next-state: flush wins, then transfer, then drain when the consumer takes the entry.
  always_comb begin
    valid_d = out_valid;
    a_d     = out_a;
    b_d     = out_b;
    imm_d   = out_imm;
    rd_d    = out_rd;
    ctrl_d  = out_ctrl;
    stall_d = stall_cnt;
    if (flush) begin
      valid_d = 1'b0;
    end else if (transfer_c) begin
      valid_d = 1'b1;
      a_d     = opa_c;
      b_d     = opb_c;
      imm_d   = in_imm;
      rd_d    = in_rd;
      ctrl_d  = in_ctrl;
    end else if (!out_valid || out_ready) begin
      valid_d = 1'b0;
    end
    if (in_valid && hazard_c && !flush && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_d = stall_cnt + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_imm   <= '0;
      out_rd    <= '0;
      out_ctrl  <= '0;
      stall_cnt <= '0;
    end else begin
      out_valid <= valid_d;
      out_a     <= a_d;
      out_b     <= b_d;
      out_imm   <= imm_d;
      out_rd    <= rd_d;
      out_ctrl  <= ctrl_d;
      stall_cnt <= stall_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_use_rs, in_use_rt;
  logic [31:0] in_imm;
  logic [7:0]  in_ctrl;
  logic [4:0]  R_addr_A, R_addr_B;
  logic [31:0] rdata_A, rdata_B;
  logic        ex_wen, ex_is_load;
  logic [4:0]  ex_addr;
  logic [31:0] ex_data;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b, out_imm;
  logic [4:0]  out_rd;
  logic [7:0]  out_ctrl;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .rdata_A(rdata_A), .rdata_B(rdata_B),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_addr(ex_addr), .ex_data(ex_data),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd0;
    in_use_rs = 1'b1; in_use_rt = 1'b1; in_imm = 32'h0; in_ctrl = 8'h0;
    rdata_A = 32'h0; rdata_B = 32'h0; ex_wen = 1'b0; ex_is_load = 1'b0;
    ex_addr = 5'd0; ex_data = 32'h0; wb_wen = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    flush = 1'b0; out_ready = 1'b1;

    // Held in reset across edges
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    check("rst_out_a",     out_a,          32'h0);
    check("rst_out_ctrl",  32'(out_ctrl),  32'h0);

    // Txn 1: EX bypass beats WB bypass; rt=0 reads zero
    rst = 1'b1;
    in_valid = 1'b1; in_rs = 5'd5; in_rt = 5'd0; in_rd = 5'd12;
    in_imm = 32'hFFFF_FFF0; in_ctrl = 8'hA5;
    rdata_A = 32'h99; rdata_B = 32'hDEAD_BEEF;
    ex_wen = 1'b1; ex_is_load = 1'b0; ex_addr = 5'd5; ex_data = 32'h11;
    wb_wen = 1'b1; wb_addr = 5'd5; wb_data = 32'h22;
    #1;
    check("raddr_a", 32'(R_addr_A), 32'd5);
    check("raddr_b", 32'(R_addr_B), 32'd0);
    check("t1_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_out_a_ex_fwd", out_a, 32'h11);
    check("t1_out_b_zero", out_b, 32'h0);
    check("t1_out_rd", 32'(out_rd), 32'd12);
    check("t1_out_imm", out_imm, 32'hFFFF_FFF0);
    check("t1_out_ctrl", 32'(out_ctrl), 32'hA5);

    // Txn 2: WB write to r0 must not leak into a read of r0
    in_rs = 5'd7; in_rt = 5'd0; in_rd = 5'd3; rdata_A = 32'h77; rdata_B = 32'hDEAD_BEEF;
    ex_wen = 1'b0; wb_wen = 1'b1; wb_addr = 5'd0; wb_data = 32'h22;
    tick();
    check("t2_out_a_rf", out_a, 32'h77);
    check("t2_out_b_zero", out_b, 32'h0);
    check("t2_out_rd", 32'(out_rd), 32'd3);

    // Txn 3: load in EX is not bypassed; WB bypass on B
    in_rs = 5'd6; in_use_rs = 1'b0; rdata_A = 32'h66;
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_addr = 5'd6; ex_data = 32'hAA;
    in_rt = 5'd9; in_use_rt = 1'b1; rdata_B = 32'h99;
    wb_wen = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    in_rd = 5'd20; in_ctrl = 8'h3C; in_imm = 32'h1234;
    #1;
    check("t3_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("t3_out_a_no_load_fwd", out_a, 32'h66);
    check("t3_out_b_wb_fwd", out_b, 32'h55);

    // Backpressure: outputs hold while inputs and bypass sources change
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rs = 5'(i + 1); in_use_rs = 1'b1; in_rt = 5'(i + 10);
      rdata_A = 32'h1000 + 32'(i); rdata_B = 32'h2000 + 32'(i);
      ex_wen = 1'b1; ex_is_load = 1'b0; ex_addr = 5'(i + 1); ex_data = 32'h100 + 32'(i);
      wb_addr = 5'(i + 10); wb_data = 32'h200 + 32'(i);
      in_rd = 5'(i); in_ctrl = 8'(i); in_imm = 32'(i);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_out_a", out_a, 32'h66);
      check("bp_out_b", out_b, 32'h55);
      check("bp_out_rd", 32'(out_rd), 32'd20);
      check("bp_out_ctrl", 32'(out_ctrl), 32'h3C);
      check("bp_out_imm", out_imm, 32'h1234);
    end

    // Drain
    out_ready = 1'b1; in_valid = 1'b0; ex_wen = 1'b0; wb_wen = 1'b0;
    tick();
    check("drain_out_valid", 32'(out_valid), 32'h0);

    // Load-use stall for two cycles
    in_valid = 1'b1; in_rs = 5'd3; in_use_rs = 1'b1; in_rt = 5'd8; in_use_rt = 1'b0;
    rdata_A = 32'h33; rdata_B = 32'h88;
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_addr = 5'd3; ex_data = 32'hBAD;
    #1;
    check("lu_in_ready_0", 32'(in_ready), 32'h0);
    tick();
    check("lu_out_valid_1", 32'(out_valid), 32'h0);
    check("lu_stall_1", 32'(stall_cnt), 32'd1);
    check("lu_in_ready_1", 32'(in_ready), 32'h0);
    tick();
    check("lu_out_valid_2", 32'(out_valid), 32'h0);
    check("lu_stall_2", 32'(stall_cnt), 32'd2);
    ex_wen = 1'b0;
    #1;
    check("lu_in_ready_clear", 32'(in_ready), 32'h1);
    tick();
    check("lu_out_valid_go", 32'(out_valid), 32'h1);
    check("lu_out_a", out_a, 32'h33);
    check("lu_stall_hold", 32'(stall_cnt), 32'd2);

    // Flush during a transfer discards it
    flush = 1'b1; in_valid = 1'b1; in_rs = 5'd4; rdata_A = 32'h44;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("fl_out_valid", 32'(out_valid), 32'h0);
    check("fl_out_a_kept", out_a, 32'h33);
    check("fl_stall", 32'(stall_cnt), 32'd2);

    // Flush during a load-use hazard does not count a stall
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_addr = 5'd4;
    tick();
    check("fl_hz_stall", 32'(stall_cnt), 32'd2);
    check("fl_hz_out_valid", 32'(out_valid), 32'h0);

    // Flush kills a held, back-pressured entry
    flush = 1'b0; ex_wen = 1'b0;
    tick();
    check("fl2_out_valid", 32'(out_valid), 32'h1);
    check("fl2_out_a", out_a, 32'h44);
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
    tick();
    check("fl2_killed", 32'(out_valid), 32'h0);

    // Async reset between edges
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_rs = 5'd4; rdata_A = 32'h45;
    tick();
    check("ar_pre_valid", 32'(out_valid), 32'h1);
    rst = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'h0);
    check("ar_stall", 32'(stall_cnt), 32'h0);
    check("ar_out_a", out_a, 32'h0);
    check("ar_in_ready", 32'(in_ready), 32'h0);
    #2;
    rst = 1'b1;
    tick();
    check("ar_first_xfer", 32'(out_valid), 32'h1);
    check("ar_first_a", out_a, 32'h45);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
